mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 32-bit pipeline. Sits directly downstream of the EXE-to-MEM pipeline register and consumes its outputs. It runs loads/stores over a req/ack data-memory bus, stalls the front of the pipe while an access is outstanding, and holds the MEM-to-WB pipeline register feeding write-back. A bounded wait timer aborts accesses that never complete.

## Interface
- TIMEOUT, 15: max cycles in ACCESS without `mem_ack` before abort (≥1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- WB_EN_IN  in  1  write-back enable from the EXE-to-MEM register.
- MEM_R_EN_IN  in  1  load request.
- MEM_W_EN_IN  in  1  store request.
- ALUResIn  in  32  ALU result / effective address.
- STValIn  in  32  store data.
- destIn  in  5  destination register.
- mem_rdata  in  32  bus read data; valid when `mem_ack`=1.
- mem_ack  in  1  bus completion, one-cycle pulse.
- mem_req  out  1  bus request (registered).
- mem_we  out  1  1 = write, 0 = read (registered).
- mem_addr  out  32  word address {ALURes[31:2], 2'b00} (registered).
- mem_wdata  out  32  store data (registered).
- freeze  out  1  stall to upstream stages (combinational).
- bus_err  out  1  sticky timeout flag.
- WB_EN  out  1  MEM-to-WB register output.
- MEM_R_EN  out  1  MEM-to-WB register output: the instruction was a load.
- ALURes  out  32  MEM-to-WB register output.
- MemData  out  32  MEM-to-WB register output: captured load data.
- dest  out  5  MEM-to-WB register output.

## Operation
- States: IDLE, ACCESS. Wait counter `wcnt` counts ACCESS cycles.
- An access is requested when `MEM_R_EN_IN | MEM_W_EN_IN`. If both are set, the write wins: it is treated as a store and the latched MEM_R_EN is 0.
- IDLE, no request:
  - MEM-to-WB register loads the inputs directly. MemData is 0.
  - freeze = 0.
- IDLE, request:
  - Latch the instruction fields.
  - Drive mem_req=1, mem_we, mem_addr and mem_wdata from the next edge.
  - Move to ACCESS and set wcnt=1.
  - freeze = 1. Load a bubble into MEM-to-WB (all fields 0).
- ACCESS, `mem_ack`=1:
  - Load MEM-to-WB from the latched fields. MemData = mem_rdata for a load, 0 for a store.
  - Drop mem_req and return to IDLE. freeze = 0.
- ACCESS, no ack, wcnt < TIMEOUT:
  - freeze = 1. Load a bubble. wcnt++.
  - Bus outputs stay stable.
- ACCESS, no ack, wcnt == TIMEOUT:
  - Abort: drop mem_req and set bus_err=1.
  - Load a bubble, so the instruction is discarded with WB_EN=0.
  - Return to IDLE. freeze = 0.
- If ack arrives in the same cycle wcnt == TIMEOUT, the ack wins and there is no abort.
- mem_ack is ignored in IDLE.
- bus_err clears only on rst.
- Upstream must hold the EXE-to-MEM register contents while freeze=1. The inputs are sampled only in IDLE.

## Timing
- Reset: all outputs 0, state IDLE, wcnt 0, bus_err 0. This takes effect at the first edge with rst=1.
- Non-memory instruction: 1-cycle latency into MEM-to-WB. No stall.
- Access with ack in the k-th ACCESS cycle (k≥1):
  - freeze is high for k cycles (the IDLE request cycle plus k−1 wait cycles).
  - The result appears in MEM-to-WB at the edge ending the ack cycle.
  - mem_req is high for exactly k cycles.
- Timeout: mem_req is high for TIMEOUT cycles, and freeze for TIMEOUT cycles.
- Back-to-back accesses: after an ack, the next request is sampled in the following IDLE cycle. mem_req has at least one low cycle between accesses.
- Reset mid-ACCESS: mem_req drops at that edge. Nothing is retried, no result is written back, and bus_err is unaffected except cleared.

## Test plan
- ALU op (WB_EN_IN=1, ALUResIn=0x1234, destIn=7, no mem) → next cycle WB_EN=1, ALURes=0x1234, dest=7, MemData=0, freeze never high.
- Load (ALUResIn=0x103, destIn=5), ack with rdata=0xDEADBEEF in the 3rd ACCESS cycle → mem_addr=0x100, mem_we=0, freeze high 3 cycles, then WB_EN=1, MEM_R_EN=1, MemData=0xDEADBEEF, dest=5.
- Store (ALUResIn=0x40, STValIn=0xA5A5A5A5), ack in the 1st ACCESS cycle → one cycle with mem_req=1, mem_we=1, mem_wdata=0xA5A5A5A5; freeze high 1 cycle; MEM-to-WB shows the latched fields with WB_EN=WB_EN_IN, MemData=0.
- Load, never acked, TIMEOUT=15 → mem_req high 15 cycles then low, bus_err=1 and stays 1, WB_EN stays 0, the next ALU op flows normally. Variant: ack in cycle 15 → no abort, bus_err=0.
- MEM_R_EN_IN=MEM_W_EN_IN=1 → store performed (mem_we=1), latched MEM_R_EN=0.
- rst pulsed in the 2nd ACCESS cycle → next cycle mem_req=0, all outputs 0, state IDLE; a late mem_ack is ignored.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and memory.
// The stage is the master; the memory model or controller is the slave.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a req/ack bus and stalls upstream.
// It holds the MEM-to-WB register and aborts accesses after a bounded wait.
module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WB_EN_IN,
    input  logic             MEM_R_EN_IN,
    input  logic             MEM_W_EN_IN,
    input  logic [31:0]      ALUResIn,
    input  logic [31:0]      STValIn,
    input  logic [4:0]       destIn,
    mem_stage_if.master      bus,
    output logic             freeze,
    output logic             bus_err,
    output logic             WB_EN,
    output logic             MEM_R_EN,
    output logic [31:0]      ALURes,
    output logic [31:0]      MemData,
    output logic [4:0]       dest
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t      r_state, w_state;
    logic [CW-1:0] r_wcnt, w_wcnt;
    logic        r_req, w_req;
    logic        r_we, w_we;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_wdata, w_wdata;
    logic        r_err, w_err;
    logic        r_lwb, w_lwb;
    logic        r_lrd, w_lrd;
    logic [31:0] r_lalu, w_lalu;
    logic [4:0]  r_ldest, w_ldest;
    logic        r_wb, w_wb;
    logic        r_rd, w_rd;
    logic [31:0] r_alu, w_alu;
    logic [31:0] r_mdata, w_mdata;
    logic [4:0]  r_dest, w_dest;
    logic        w_freeze;
    logic        w_access;

    assign w_access = MEM_R_EN_IN | MEM_W_EN_IN;

    // Next-state, bus and MEM-to-WB values; the MEM-to-WB default is a bubble
    always_comb begin
        w_state  = r_state;
        w_wcnt   = r_wcnt;
        w_req    = r_req;
        w_we     = r_we;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_err    = r_err;
        w_lwb    = r_lwb;
        w_lrd    = r_lrd;
        w_lalu   = r_lalu;
        w_ldest  = r_ldest;
        w_wb     = 1'b0;
        w_rd     = 1'b0;
        w_alu    = '0;
        w_mdata  = '0;
        w_dest   = '0;
        w_freeze = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_lwb    = WB_EN_IN;
                    w_lrd    = MEM_R_EN_IN & ~MEM_W_EN_IN;
                    w_lalu   = ALUResIn;
                    w_ldest  = destIn;
                    w_req    = 1'b1;
                    w_we     = MEM_W_EN_IN;
                    w_addr   = {ALUResIn[31:2], 2'b00};
                    w_wdata  = STValIn;
                    w_state  = S_ACCESS;
                    w_wcnt   = CW'(1);
                    w_freeze = 1'b1;
                end else begin
                    w_wb   = WB_EN_IN;
                    w_alu  = ALUResIn;
                    w_dest = destIn;
                end
            end
            S_ACCESS: begin
                if (bus.mem_ack) begin
                    w_wb    = r_lwb;
                    w_rd    = r_lrd;
                    w_alu   = r_lalu;
                    w_dest  = r_ldest;
                    w_mdata = r_lrd ? bus.mem_rdata : 32'h0;
                    w_req   = 1'b0;
                    w_state = S_IDLE;
                    w_wcnt  = '0;
                end else if (r_wcnt == LIMIT) begin
                    w_req   = 1'b0;
                    w_err   = 1'b1;
                    w_state = S_IDLE;
                    w_wcnt  = '0;
                end else begin
                    w_freeze = 1'b1;
                    w_wcnt   = r_wcnt + CW'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // State, bus and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_lwb   <= 1'b0;
            r_lrd   <= 1'b0;
            r_lalu  <= '0;
            r_ldest <= '0;
            r_wb    <= 1'b0;
            r_rd    <= 1'b0;
            r_alu   <= '0;
            r_mdata <= '0;
            r_dest  <= '0;
        end else begin
            r_state <= w_state;
            r_wcnt  <= w_wcnt;
            r_req   <= w_req;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_err   <= w_err;
            r_lwb   <= w_lwb;
            r_lrd   <= w_lrd;
            r_lalu  <= w_lalu;
            r_ldest <= w_ldest;
            r_wb    <= w_wb;
            r_rd    <= w_rd;
            r_alu   <= w_alu;
            r_mdata <= w_mdata;
            r_dest  <= w_dest;
        end
    end

    assign bus.mem_req   = r_req;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign freeze        = w_freeze;
    assign bus_err       = r_err;
    assign WB_EN         = r_wb;
    assign MEM_R_EN      = r_rd;
    assign ALURes        = r_alu;
    assign MemData       = r_mdata;
    assign dest          = r_dest;
endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a transaction-level model.
// Each access is predicted from its ack cycle k: stall length, bus window, result.
module tb_mem_stage;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
    logic [31:0] ALUResIn, STValIn;
    logic [4:0]  destIn;
    logic        freeze, bus_err, WB_EN, MEM_R_EN;
    logic [31:0] ALURes, MemData;
    logic [4:0]  dest;

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN),
        .MEM_W_EN_IN(MEM_W_EN_IN), .ALUResIn(ALUResIn),
        .STValIn(STValIn), .destIn(destIn), .bus(bus),
        .freeze(freeze), .bus_err(bus_err), .WB_EN(WB_EN),
        .MEM_R_EN(MEM_R_EN), .ALURes(ALURes),
        .MemData(MemData), .dest(dest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_nop();
        WB_EN_IN = 1'b0; MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0;
        ALUResIn = '0; STValIn = '0; destIn = '0;
    endtask

    task automatic chk_wb(input string tag, input logic wb, input logic rd,
                          input logic [31:0] alu, input logic [31:0] md,
                          input logic [4:0] dst);
        chk({tag, "_wb"}, 32'(WB_EN), 32'(wb));
        chk({tag, "_rd"}, 32'(MEM_R_EN), 32'(rd));
        chk({tag, "_alu"}, ALURes, alu);
        chk({tag, "_mdata"}, MemData, md);
        chk({tag, "_dest"}, 32'(dest), 32'(dst));
    endtask

    // Called just after a rising edge with the stage idle.
    task automatic do_alu(input logic wb, input logic [31:0] alu,
                          input logic [4:0] dst);
        WB_EN_IN = wb; MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0;
        ALUResIn = alu; STValIn = $urandom; destIn = dst;
        @(negedge clk);
        chk("alu_freeze", 32'(freeze), 32'h0);
        @(posedge clk); #1;
        chk_wb("alu", wb, 1'b0, alu, 32'h0, dst);
        chk("alu_err", 32'(bus_err), 32'(exp_err));
    endtask

    // k in 1..TMO: ack in k-th ACCESS cycle; otherwise never acked.
    task automatic do_mem(input logic wb, input logic r, input logic w,
                          input logic [31:0] alu, input logic [31:0] st,
                          input logic [4:0] dst, input int k,
                          input logic [31:0] rd);
        bit acked;
        bit is_ld;
        int n;
        int rq;
        acked = (k >= 1 && k <= TMO);
        is_ld = r && !w;
        n = acked ? k : TMO;
        rq = 0;
        WB_EN_IN = wb; MEM_R_EN_IN = r; MEM_W_EN_IN = w;
        ALUResIn = alu; STValIn = st; destIn = dst;
        @(negedge clk);
        chk("req_freeze", 32'(freeze), 32'h1);
        chk("req_idle", 32'(bus.mem_req), 32'h0);
        @(posedge clk); #1;
        for (int j = 1; j <= n; j++) begin
            if (bus.mem_req) rq++;
            chk("bus_addr", bus.mem_addr, {alu[31:2], 2'b00});
            chk("bus_we", 32'(bus.mem_we), 32'(w));
            if (w) chk("bus_wdata", bus.mem_wdata, st);
            chk("wait_bubble", 32'(WB_EN), 32'h0);
            if (acked && j == k) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = rd;
            end
            @(negedge clk);
            chk("wait_freeze", 32'(freeze), 32'(j < n));
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            bus.mem_rdata = $urandom;
        end
        set_nop();
        chk("req_cycles", 32'(rq), 32'(n));
        chk("req_drop", 32'(bus.mem_req), 32'h0);
        if (acked) begin
            chk_wb("done", wb, is_ld, alu, is_ld ? rd : 32'h0, dst);
        end else begin
            exp_err = 1'b1;
            chk_wb("abort", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        end
        chk("err_flag", 32'(bus_err), 32'(exp_err));
    endtask

    initial begin
        rst = 1'b1;
        set_nop();
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        @(posedge clk); #1;
        chk("rst_req", 32'(bus.mem_req), 32'h0);
        chk("rst_err", 32'(bus_err), 32'h0);
        chk("rst_freeze", 32'(freeze), 32'h0);
        chk_wb("rst", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rst = 1'b0;

        do_alu(1'b1, 32'h1234, 5'd7);
        do_mem(1'b1, 1'b1, 1'b0, 32'h103, 32'h0, 5'd5, 3, 32'hDEADBEEF);
        do_mem(1'b0, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 5'd0, 1, 32'h0);
        do_mem(1'b1, 1'b1, 1'b1, 32'h8008, 32'h12345678, 5'd9, 2,
               32'h55AA55AA);
        do_mem(1'b1, 1'b1, 1'b0, 32'h2001, 32'h0, 5'd3, TMO, 32'hCAFEF00D);

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_alu(1'($urandom), $urandom, 5'($urandom));
            end else begin
                logic rr, ww;
                rr = 1'($urandom);
                ww = rr ? 1'($urandom) : 1'b1;
                do_mem(1'($urandom), rr, ww, $urandom, $urandom,
                       5'($urandom), int'($urandom_range(1, 6)), $urandom);
            end
        end

        do_mem(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd4, 0, 32'h0);
        do_alu(1'b1, 32'h77, 5'd2);
        do_mem(1'b1, 1'b0, 1'b1, 32'h304, 32'h99, 5'd0, 1, 32'h0);

        WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b1; MEM_W_EN_IN = 1'b0;
        ALUResIn = 32'h500; destIn = 5'd6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_req", 32'(bus.mem_req), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_nop();
        exp_err = 1'b0;
        chk("mrst_req", 32'(bus.mem_req), 32'h0);
        chk("mrst_err", 32'(bus_err), 32'h0);
        chk_wb("mrst", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        chk("late_freeze", 32'(freeze), 32'h0);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("late_req", 32'(bus.mem_req), 32'h0);
        chk_wb("late", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        do_alu(1'b1, 32'hABCD, 5'd31);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
